// File: rtl/tcdm_bank_pkg.sv
// rtl/tcdm_bank_pkg.sv - shared types and helpers for the TCDM bank arbiter
package tcdm_bank_pkg;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_sel_e;

  // Counter width able to hold the value 0..limit inclusive.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/tcdm_bank_resp_pipe.sv
// rtl/tcdm_bank_resp_pipe.sv - fixed-depth shift register of response tags
module tcdm_bank_resp_pipe #(
  parameter int Depth = 1,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] tag_i,
  output logic [Width-1:0] tag_o
);

  logic [Depth-1:0][Width-1:0] stage_q;

  if (Depth == 1) begin : g_single
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else begin
        stage_q <= tag_i;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[Depth-2:0], tag_i};
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - per-bank A/B arbiter with starvation guard and response routing
module tcdm_bank_arbiter
  import tcdm_bank_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int AddrMemWidth = 12,
  parameter int IniAddWidth  = 5,
  parameter int MemLatency   = 1,
  parameter int StarveLimit  = 4,
  parameter bit WriteRespOn  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [AddrMemWidth-1:0] a_add_i,
  input  logic                    a_wen_i,
  input  logic [DataWidth-1:0]    a_wdata_i,
  input  logic [BeWidth-1:0]      a_be_i,
  input  logic [IniAddWidth-1:0]  a_ini_add_i,
  output logic                    a_vld_o,
  output logic [IniAddWidth-1:0]  a_ini_add_o,
  output logic [DataWidth-1:0]    a_rdata_o,

  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [AddrMemWidth-1:0] b_add_i,
  input  logic                    b_wen_i,
  input  logic [DataWidth-1:0]    b_wdata_i,
  input  logic [BeWidth-1:0]      b_be_i,
  output logic                    b_vld_o,
  output logic [DataWidth-1:0]    b_rdata_o,

  output logic                    mem_req_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic                    mem_wen_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  if (MemLatency < 1) begin : g_bad_latency
    $fatal(1, "tcdm_bank_arbiter: MemLatency must be >= 1");
  end
  if (StarveLimit < 1) begin : g_bad_starve
    $fatal(1, "tcdm_bank_arbiter: StarveLimit must be >= 1");
  end

  localparam int StarveW = starve_cnt_width(StarveLimit);

  typedef struct packed {
    logic                   valid;
    port_sel_e              port;
    logic [IniAddWidth-1:0] ini_add;
    logic                   wen;
  } tag_t;

  localparam int TagW = $bits(tag_t);

  logic [StarveW-1:0] starve_q;
  logic               starved;
  logic               b_win;
  logic               a_gnt;
  logic               b_gnt;

  // B only overrides A once it has been denied StarveLimit cycles in a row.
  assign starved = (starve_q == StarveW'(StarveLimit));
  assign b_win   = b_req_i & (~a_req_i | starved);
  assign b_gnt   = ~rst_i & b_win;
  assign a_gnt   = ~rst_i & a_req_i & ~b_win;

  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;

  assign mem_req_o   = a_gnt | b_gnt;
  assign mem_add_o   = b_gnt ? b_add_i   : a_add_i;
  assign mem_wen_o   = b_gnt ? b_wen_i   : a_wen_i;
  assign mem_wdata_o = b_gnt ? b_wdata_i : a_wdata_i;
  assign mem_be_o    = b_gnt ? b_be_i    : a_be_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (b_req_i && !b_gnt) begin
      if (!starved) begin
        starve_q <= starve_q + StarveW'(1);
      end
    end else begin
      starve_q <= '0;
    end
  end

  tag_t            tag_in;
  tag_t            tag_out;
  logic [TagW-1:0] tag_in_bits;
  logic [TagW-1:0] tag_out_bits;

  // Writes only occupy a response slot when write responses are enabled.
  always_comb begin
    tag_in         = '0;
    tag_in.valid   = mem_req_o & (~mem_wen_o | WriteRespOn);
    tag_in.port    = b_gnt ? PortB : PortA;
    tag_in.ini_add = b_gnt ? '0 : a_ini_add_i;
    tag_in.wen     = mem_wen_o;
  end

  assign tag_in_bits = tag_in;

  tcdm_bank_resp_pipe #(
    .Depth (MemLatency),
    .Width (TagW)
  ) u_resp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_in_bits),
    .tag_o (tag_out_bits)
  );

  assign tag_out = tag_t'(tag_out_bits);

  logic                 rsp_live;
  logic                 a_rsp;
  logic                 b_rsp;
  logic [DataWidth-1:0] rsp_data;

  assign rsp_live = ~rst_i & tag_out.valid;
  assign a_rsp    = rsp_live & (tag_out.port == PortA);
  assign b_rsp    = rsp_live & (tag_out.port == PortB);
  assign rsp_data = tag_out.wen ? '0 : mem_rdata_i;

  assign a_vld_o     = a_rsp;
  assign a_rdata_o   = a_rsp ? rsp_data : '0;
  assign a_ini_add_o = a_rsp ? tag_out.ini_add : '0;
  assign b_vld_o     = b_rsp;
  assign b_rdata_o   = b_rsp ? rsp_data : '0;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// tb/tb_tcdm_bank_arbiter.sv - self-checking bench for tcdm_bank_arbiter
module tb_tcdm_bank_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        tb_init;
  logic        a_req, a_wen, b_req, b_wen;
  logic [11:0] a_add, b_add;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_be, b_be;
  logic [4:0]  a_ini;

  logic        a_gnt, b_gnt, a_vld, b_vld, mem_req, mem_wen;
  logic [4:0]  a_ini_o;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_add;
  logic [3:0]  mem_be;

  logic        nw_a_gnt, nw_b_gnt, nw_a_vld, nw_b_vld, nw_mem_req, nw_mem_wen;
  logic [4:0]  nw_a_ini_o;
  logic [31:0] nw_a_rdata, nw_b_rdata, nw_mem_wdata;
  logic [11:0] nw_mem_add;
  logic [3:0]  nw_mem_be;

  tcdm_bank_arbiter #(
    .MemLatency (LAT), .StarveLimit (STARVE), .WriteRespOn (1'b1)
  ) u_dut (
    .clk_i (clk), .rst_i (rst),
    .a_req_i (a_req), .a_gnt_o (a_gnt), .a_add_i (a_add), .a_wen_i (a_wen),
    .a_wdata_i (a_wdata), .a_be_i (a_be), .a_ini_add_i (a_ini),
    .a_vld_o (a_vld), .a_ini_add_o (a_ini_o), .a_rdata_o (a_rdata),
    .b_req_i (b_req), .b_gnt_o (b_gnt), .b_add_i (b_add), .b_wen_i (b_wen),
    .b_wdata_i (b_wdata), .b_be_i (b_be), .b_vld_o (b_vld), .b_rdata_o (b_rdata),
    .mem_req_o (mem_req), .mem_add_o (mem_add), .mem_wen_o (mem_wen),
    .mem_wdata_o (mem_wdata), .mem_be_o (mem_be), .mem_rdata_i (mem_rdata)
  );

  // Same stimulus and bank data, but writes produce no response.
  tcdm_bank_arbiter #(
    .MemLatency (LAT), .StarveLimit (STARVE), .WriteRespOn (1'b0)
  ) u_dut_nw (
    .clk_i (clk), .rst_i (rst),
    .a_req_i (a_req), .a_gnt_o (nw_a_gnt), .a_add_i (a_add), .a_wen_i (a_wen),
    .a_wdata_i (a_wdata), .a_be_i (a_be), .a_ini_add_i (a_ini),
    .a_vld_o (nw_a_vld), .a_ini_add_o (nw_a_ini_o), .a_rdata_o (nw_a_rdata),
    .b_req_i (b_req), .b_gnt_o (nw_b_gnt), .b_add_i (b_add), .b_wen_i (b_wen),
    .b_wdata_i (b_wdata), .b_be_i (b_be), .b_vld_o (nw_b_vld), .b_rdata_o (nw_b_rdata),
    .mem_req_o (nw_mem_req), .mem_add_o (nw_mem_add), .mem_wen_o (nw_mem_wen),
    .mem_wdata_o (nw_mem_wdata), .mem_be_o (nw_mem_be), .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: 64 words, read data LAT cycles after the request, junk otherwise.
  logic [31:0] sram    [64];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= 32'h0;
      sram[6'h10] <= 32'hDEAD_BEEF;
    end else if (mem_req && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_add[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= (mem_req && !mem_wen) ? sram[mem_add[5:0]] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    int          due;
    bit          port;
    logic [4:0]  ini;
    logic [31:0] data;
    bit          wr;
  } rsp_t;

  typedef struct {
    bit a_req;
    bit b_req;
    bit exp_a;
    bit exp_b;
  } vec_t;

  rsp_t        rsp_q[$];
  vec_t        tbl[$];
  logic [31:0] shadow [64];
  int          wait_cnt;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic [11:0] add, input logic wen,
                       input logic [31:0] wd, input logic [3:0] be, input logic [4:0] ini);
    a_req = req; a_add = add; a_wen = wen; a_wdata = wd; a_be = be; a_ini = ini;
  endtask

  task automatic set_b(input logic req, input logic [11:0] add, input logic wen,
                       input logic [31:0] wd, input logic [3:0] be);
    b_req = req; b_add = add; b_wen = wen; b_wdata = wd; b_be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 12'h0, 1'b0, 32'h0, 4'h0, 5'h0);
    set_b(1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
  endtask

  function automatic vec_t mk(input bit a, input bit b, input bit ea, input bit eb);
    vec_t v;
    v.a_req = a; v.b_req = b; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // One clock of the reference model: check this cycle's outputs, then advance.
  task automatic tick();
    rsp_t        e;
    rsp_t        n;
    bit          have;
    bit          ea, eb, ev_a, ev_b;
    logic [11:0] g_add;
    logic        g_wen;
    logic [31:0] g_wd;
    logic [3:0]  g_be;
    @(negedge clk);
    eb = !rst && b_req && (!a_req || wait_cnt >= STARVE);
    ea = !rst && a_req && !eb;
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("mem_req", mem_req, ea | eb);
    chk("nw_a_gnt", nw_a_gnt, ea);
    chk("nw_b_gnt", nw_b_gnt, eb);
    g_add = eb ? b_add : a_add;
    g_wen = eb ? b_wen : a_wen;
    g_wd  = eb ? b_wdata : a_wdata;
    g_be  = eb ? b_be : a_be;
    if (ea || eb) begin
      chk("mem_add", mem_add, g_add);
      chk("mem_wen", mem_wen, g_wen);
      chk("mem_wdata", mem_wdata, g_wd);
      chk("mem_be", mem_be, g_be);
    end
    if (rst) rsp_q.delete();
    have = 1'b0;
    e = '{due: 0, port: 1'b0, ini: 5'h0, data: 32'h0, wr: 1'b0};
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      e = rsp_q.pop_front();
      have = 1'b1;
    end
    ev_a = have && !e.port;
    ev_b = have && e.port;
    chk("a_vld", a_vld, ev_a);
    chk("a_rdata", a_rdata, ev_a ? e.data : 32'h0);
    chk("a_ini_add", a_ini_o, ev_a ? e.ini : 5'h0);
    chk("b_vld", b_vld, ev_b);
    chk("b_rdata", b_rdata, ev_b ? e.data : 32'h0);
    chk("nw_a_vld", nw_a_vld, ev_a && !e.wr);
    chk("nw_a_rdata", nw_a_rdata, (ev_a && !e.wr) ? e.data : 32'h0);
    chk("nw_a_ini_add", nw_a_ini_o, (ev_a && !e.wr) ? e.ini : 5'h0);
    chk("nw_b_vld", nw_b_vld, ev_b && !e.wr);
    chk("nw_b_rdata", nw_b_rdata, (ev_b && !e.wr) ? e.data : 32'h0);
    if (ea || eb) begin
      n.due  = cyc + LAT;
      n.port = eb;
      n.ini  = eb ? 5'h0 : a_ini;
      n.wr   = g_wen;
      n.data = g_wen ? 32'h0 : shadow[g_add[5:0]];
      rsp_q.push_back(n);
      if (g_wen)
        for (int b = 0; b < 4; b++)
          if (g_be[b]) shadow[g_add[5:0]][b*8 +: 8] = g_wd[b*8 +: 8];
    end
    if (rst) wait_cnt = 0;
    else if (b_req && !eb) wait_cnt = (wait_cnt + 1 > STARVE) ? STARVE : wait_cnt + 1;
    else wait_cnt = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; wait_cnt = 0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    shadow[16] = 32'hDEAD_BEEF;
    rst = 1'b1; tb_init = 1'b1;
    idle();
    @(posedge clk);
    #1;
    tb_init = 1'b0;

    // Reset state with requests pending.
    set_a(1'b1, 12'h010, 1'b0, 32'h0, 4'hF, 5'd3);
    set_b(1'b1, 12'h011, 1'b0, 32'h0, 4'hF);
    #1;
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_a_vld", a_vld, 1'b0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    repeat (3) tick();

    // Single A read, LAT=2.
    set_a(1'b1, 12'h010, 1'b0, 32'h0, 4'hF, 5'd7);
    #1;
    chk("t1_a_gnt", a_gnt, 1'b1);
    chk("t1_mem_add", mem_add, 12'h010);
    tick();
    idle();
    #1;
    chk("t1_a_vld_early", a_vld, 1'b0);
    tick();
    #1;
    chk("t1_a_vld", a_vld, 1'b1);
    chk("t1_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t1_a_ini", a_ini_o, 5'd7);
    chk("t1_b_vld", b_vld, 1'b0);
    tick();
    tick();

    // Grant pattern table: continuous contention, then withdrawn B request.
    for (int i = 0; i < 2; i++) begin
      repeat (4) tbl.push_back(mk(1, 1, 1, 0));
      tbl.push_back(mk(1, 1, 0, 1));
    end
    tbl.push_back(mk(0, 0, 0, 0));
    repeat (3) tbl.push_back(mk(1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0));
    repeat (4) tbl.push_back(mk(1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1));
    foreach (tbl[i]) begin
      set_a(tbl[i].a_req, 12'h010, 1'b0, 32'h0, 4'hF, 5'(i));
      set_b(tbl[i].b_req, 12'h011, 1'b0, 32'h0, 4'hF);
      #1;
      chk("tbl_a_gnt", a_gnt, tbl[i].exp_a);
      chk("tbl_b_gnt", b_gnt, tbl[i].exp_b);
      chk("tbl_excl", a_gnt & b_gnt, 1'b0);
      tick();
    end
    idle();
    repeat (3) tick();

    // B partial write, then A reads it back.
    set_b(1'b1, 12'h020, 1'b1, 32'h1234_5678, 4'b0011);
    #1;
    chk("t3_b_gnt", b_gnt, 1'b1);
    chk("t3_mem_wen", mem_wen, 1'b1);
    tick();
    idle();
    set_a(1'b1, 12'h020, 1'b0, 32'h0, 4'hF, 5'd9);
    #1;
    chk("t3_a_gnt", a_gnt, 1'b1);
    tick();
    idle();
    #1;
    chk("t3_b_vld", b_vld, 1'b1);
    chk("t3_b_rdata", b_rdata, 32'h0);
    chk("t3_nw_b_vld", nw_b_vld, 1'b0);
    tick();
    #1;
    chk("t3_a_vld", a_vld, 1'b1);
    chk("t3_a_rdata", a_rdata, 32'h0000_5678);
    tick();
    tick();

    // Three back-to-back A writes.
    for (int k = 0; k < 6; k++) begin
      if (k < 3) set_a(1'b1, 12'(12'h030 + k), 1'b1, 32'hA5A5_0000 + k, 4'hF, 5'(k + 1));
      else idle();
      #1;
      if (k < 3) begin
        chk("t4_mem_req", mem_req, 1'b1);
        chk("t4_mem_wen", mem_wen, 1'b1);
      end
      chk("t4_nw_a_vld", nw_a_vld, 1'b0);
      if (k >= 2 && k < 5) begin
        chk("t4_a_vld", a_vld, 1'b1);
        chk("t4_a_rdata", a_rdata, 32'h0);
      end
      tick();
    end

    // Reset with two reads in flight and a partly built starvation count.
    set_a(1'b1, 12'h010, 1'b0, 32'h0, 4'hF, 5'd4);
    set_b(1'b1, 12'h011, 1'b0, 32'h0, 4'hF);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_a_vld", a_vld, 1'b0);
    chk("t5_rst_a_rdata", a_rdata, 32'h0);
    chk("t5_rst_gnt", a_gnt | b_gnt, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_a_gnt", a_gnt, k < 4);
      chk("t5_b_gnt", b_gnt, k == 4);
      if (k < 2) chk("t5_a_vld_drop", a_vld, 1'b0);
      if (k == 2) begin
        chk("t5_a_vld", a_vld, 1'b1);
        chk("t5_a_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("t5_a_ini", a_ini_o, 5'd4);
      end
      tick();
    end
    idle();
    repeat (3) tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_a($urandom_range(0, 2) != 0, 12'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      set_b($urandom_range(0, 1) == 1, 12'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            $urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
Per-bank controller between one target port of the variable-latency interconnect (port A) and one DMA/refill port (port B), sharing a single fixed-latency SRAM bank.
- Arbitrates A and B with A-priority plus a starvation guard for B.
- Drives the bank and tracks in-flight accesses in a tag pipeline.
- Routes each response, with its initiator address, back to the port that issued it.
- Neither response path has back-pressure: the interconnect's target response queue absorbs A responses.

Parameters:
DataWidth, 32, data word width
BeWidth, DataWidth/8, byte-enable width
AddrMemWidth, 12, bank word address width
IniAddWidth, 5, initiator address width (clog2 of interconnect NumIn)
MemLatency, 1, SRAM read latency in cycles, legal range >=1
StarveLimit, 4, consecutive denied B cycles before B is forced through, legal range >=1
WriteRespOn, 1, writes return a response (vld pulse) when 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
a_req_i  in  1  port A request
a_gnt_o  out  1  port A grant
a_add_i  in  AddrMemWidth  port A word address
a_wen_i  in  1  port A write enable
a_wdata_i  in  DataWidth  port A write data
a_be_i  in  BeWidth  port A byte enable
a_ini_add_i  in  IniAddWidth  initiator address of the port A request
a_vld_o  out  1  port A response valid
a_ini_add_o  out  IniAddWidth  initiator address of the port A response
a_rdata_o  out  DataWidth  port A response data
b_req_i, b_gnt_o, b_add_i, b_wen_i, b_wdata_i, b_be_i  same as A, port B (no initiator address)
b_vld_o  out  1  port B response valid
b_rdata_o  out  DataWidth  port B response data
mem_req_o  out  1  bank access
mem_add_o  out  AddrMemWidth  bank address
mem_wen_o  out  1  bank write
mem_wdata_o  out  DataWidth  bank write data
mem_be_o  out  BeWidth  bank byte enable
mem_rdata_i  in  DataWidth  bank read data, valid MemLatency cycles after mem_req_o

Behaviour:
- Reset: synchronous, active-high, single clock. Applies regardless of in-flight state.
  - Clears the starvation counter and all tag pipeline stages.
  - In-flight responses are dropped and never emitted.
  - While rst_i=1: a_gnt_o, b_gnt_o, mem_req_o, a_vld_o and b_vld_o are 0; rdata and ini_add outputs are '0.
- Grant: combinational, same cycle as the request, at most one per cycle.
  - Default: a_req_i wins.
  - If starve_q==StarveLimit and b_req_i=1, B wins even when a_req_i=1.
  - Whichever port is granted, mem_* carries that port's fields and mem_req_o=1. The bank always accepts.
- Starvation counter: width clog2(StarveLimit+1).
  - Increments when b_req_i=1 and b_gnt_o=0; saturates at StarveLimit.
  - Clears when b_gnt_o=1 or b_req_i=0.
  - A denied A request holds its request (TCDM rule); no state is kept for A.
- Tag pipeline: MemLatency stages, each holding {valid, port, ini_add, wen}.
  - Stage 0 loads on any grant; stages shift every cycle.
  - A read granted in cycle t appears on the owner's vld in cycle t+MemLatency, with rdata=mem_rdata_i in that cycle and ini_add taken from the tag.
  - Writes complete in the bank in cycle t.
  - With WriteRespOn=1, a write gets a vld pulse at t+MemLatency with rdata '0. With WriteRespOn=0, the tag is not marked valid and no vld is produced.
  - Back-to-back grants give one response per cycle, in order. The non-owning port's vld is 0 and its rdata is '0.
- Boundary conditions:
  - Simultaneous A and B requests with starve_q<StarveLimit: A granted, counter increments.
  - B request dropped before its grant: counter clears.
  - A response and a new grant can coexist in the same cycle; there are no structural hazards.
- Elaboration $fatal if MemLatency<1 or StarveLimit<1.

Decomposition:
- Shared package tcdm_bank_pkg holds port_sel_e (PortA=1'b0, PortB=1'b1).
- The tag struct is local to the module because its width depends on parameters.
- One sub-module, tcdm_bank_resp_pipe: parameterised shift register of tags with synchronous clear, taking Depth=MemLatency.

Test Plan:
1. Only A reads address 0x010 (bank word 0x010 holds 0xDEAD_BEEF), MemLatency=2, a_ini_add_i=7, grant at cycle 5 -> a_gnt_o=1 at cycle 5; a_vld_o=1 at cycle 7 with a_rdata_o=0xDEAD_BEEF and a_ini_add_o=7; b_vld_o stays 0.
2. A and B both request continuously, StarveLimit=4 -> A is granted for 4 cycles, B on the 5th, pattern repeats; a_gnt_o and b_gnt_o are never 1 together.
3. B writes 0x1234_5678 with be=4'b0011 to 0x020, then A reads 0x020 (word previously 0x0) -> A read returns 0x0000_5678; with WriteRespOn=1, b_vld_o pulses MemLatency cycles after the write grant.
4. WriteRespOn=0, A issues 3 writes back-to-back -> a_vld_o stays 0 throughout, and all 3 mem_req_o cycles carry mem_wen_o=1.
5. Two reads granted in flight, rst_i asserted for 1 cycle -> no vld on either port afterwards; the starvation counter restarts from 0, and the first post-reset read returns correctly.
6. B request withdrawn after 3 denied cycles, then reasserted -> B needs 4 further denied cycles before it is forced through.
